// File: rtl/button_pkg.sv
// Shared types and default timing for the pushbutton debouncer.
// Defaults assume the 125 MHz system clock (10 ms qualify, 2 s long press).
package button_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF   = 1_250_000;
  localparam int unsigned LONG_PRESS_CYCLES_DEF = 250_000_000;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_DEB   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_DEB = 2'd3
  } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; output lags input by 2 clocks.
// Reset value is a parameter so an idle-high pin does not look active out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces an active-low pushbutton: level, press/release/long-press strobes, press count.
// Press strobe appears DEBOUNCE_CYCLES+3 clocks after the pin goes low; all outputs registered.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
  input  logic       clk_125mhz,
  input  logic       reset_n,
  input  logic       button_raw,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned CW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_PRESS_CYCLES - 1);

  if (LONG_PRESS_CYCLES < DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_PRESS_CYCLES must be >= DEBOUNCE_CYCLES");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 2");
  end

  logic       sync;
  btn_state_t state_q, state_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic       long_done_q, long_done_d;
  logic       pressed_q, pressed_d;
  logic       press_pulse_q, press_pulse_d;
  logic       release_pulse_q, release_pulse_d;
  logic       long_pulse_q, long_pulse_d;
  logic [7:0] press_count_q, press_count_d;

  // Pin idles high (released), so the synchronizer resets to 1.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_i   (clk_125mhz),
    .rst_n_i (reset_n),
    .d_i     (button_raw),
    .q_o     (sync)
  );

  always_comb begin
    state_d         = state_q;
    deb_cnt_d       = deb_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    long_done_d     = long_done_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;
    press_count_d   = press_count_q;

    case (state_q)
      RELEASED: begin
        if (!sync) begin
          state_d   = PRESS_DEB;
          deb_cnt_d = '0;
        end
      end
      PRESS_DEB: begin
        if (sync) begin
          state_d = RELEASED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d       = PRESSED;
          pressed_d     = 1'b1;
          press_pulse_d = 1'b1;
          hold_cnt_d    = '0;
          long_done_d   = 1'b0;
          press_count_d = press_count_q + 8'd1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (!long_done_q) begin
          long_pulse_d = 1'b1;
          long_done_d  = 1'b1;
        end
        if (sync) begin
          state_d   = RELEASE_DEB;
          deb_cnt_d = '0;
        end
      end
      RELEASE_DEB: begin
        if (!sync) begin
          state_d = PRESSED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d         = RELEASED;
          pressed_d       = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk_125mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= RELEASED;
      deb_cnt_q       <= '0;
      hold_cnt_q      <= '0;
      long_done_q     <= 1'b0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      press_count_q   <= 8'd0;
    end else begin
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      long_done_q     <= long_done_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      press_count_q   <= press_count_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;
  assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32.
module tb_button_debounce;

  logic       clk_125mhz = 1'b0;
  logic       reset_n    = 1'b0;
  logic       button_raw = 1'b1;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_press = 0, n_release = 0, n_long = 0, n_overlap = 0;
  int press_cyc = 0, long_cyc = 0;
  int s_press, s_release, s_long;

  button_debounce #(.DEBOUNCE_CYCLES(8), .LONG_PRESS_CYCLES(32)) dut (
    .clk_125mhz    (clk_125mhz),
    .reset_n       (reset_n),
    .button_raw    (button_raw),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  always @(posedge clk_125mhz) cyc <= cyc + 1;

  always @(negedge clk_125mhz) begin
    if (press_pulse)   begin n_press++;   press_cyc = cyc; end
    if (release_pulse) n_release++;
    if (long_pulse)    begin n_long++;    long_cyc = cyc; end
    if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) > 1) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_125mhz);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic snap();
    s_press   = n_press;
    s_release = n_release;
    s_long    = n_long;
  endtask

  initial begin
    // Reset state
    button_raw = 1'b1;
    reset_n    = 1'b0;
    step(3);
    check("rst_pressed", {31'd0, pressed}, 0);
    check("rst_pulses", {29'd0, press_pulse, release_pulse, long_pulse}, 0);
    check("rst_count", {24'd0, press_count}, 0);
    reset_n = 1'b1;
    step(2);

    // Clean press: strobe right after edge 11, long strobe 32 cycles later
    snap();
    button_raw = 1'b0;
    step(10);
    check("clean_pp_edge10", {31'd0, press_pulse}, 0);
    step(1);
    check("clean_pp_edge11", {31'd0, press_pulse}, 1);
    check("clean_pressed", {31'd0, pressed}, 1);
    check("clean_count", {24'd0, press_count}, 1);
    step(1);
    check("clean_pp_single", {31'd0, press_pulse}, 0);
    step(38);
    check("clean_long_once", n_long - s_long, 1);
    check("clean_long_delay", long_cyc - press_cyc, 32);
    button_raw = 1'b1;
    step(11);
    check("clean_rel_edge11", {31'd0, release_pulse}, 1);
    step(10);
    check("clean_released", {31'd0, pressed}, 0);
    check("clean_rel_once", n_release - s_release, 1);

    // Bounce: four 5-cycle low blips never qualify
    do_reset();
    snap();
    for (int i = 0; i < 4; i++) begin
      button_raw = 1'b0;
      step(5);
      button_raw = 1'b1;
      step(5);
    end
    step(10);
    check("bounce_no_press", n_press - s_press, 0);
    check("bounce_no_rel", n_release - s_release, 0);
    check("bounce_pressed", {31'd0, pressed}, 0);
    check("bounce_count", {24'd0, press_count}, 0);

    // Short press with a 3-cycle release glitch
    do_reset();
    snap();
    button_raw = 1'b0;
    step(20);
    button_raw = 1'b1;
    step(3);
    button_raw = 1'b0;
    step(10);
    check("glitch_still_pressed", {31'd0, pressed}, 1);
    button_raw = 1'b1;
    step(30);
    check("glitch_press_once", n_press - s_press, 1);
    check("glitch_rel_once", n_release - s_release, 1);
    check("glitch_no_long", n_long - s_long, 0);
    check("glitch_count", {24'd0, press_count}, 1);

    // Reset mid-press, button kept low throughout
    do_reset();
    snap();
    button_raw = 1'b0;
    step(11);
    check("midrst_first_pp", {31'd0, press_pulse}, 1);
    step(4);
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", {23'd0, pressed, press_pulse, release_pulse, long_pulse, press_count}, 0);
    step(4);
    reset_n = 1'b1;
    step(10);
    check("midrst_pp_edge10", {31'd0, press_pulse}, 0);
    step(1);
    check("midrst_pp_edge11", {31'd0, press_pulse}, 1);
    check("midrst_count", {24'd0, press_count}, 1);
    check("midrst_no_rel", n_release - s_release, 0);
    button_raw = 1'b1;
    step(20);

    // Wrap: 256 qualified presses
    do_reset();
    snap();
    for (int i = 0; i < 256; i++) begin
      button_raw = 1'b0;
      step(14);
      button_raw = 1'b1;
      step(14);
      if (i == 254) check("wrap_count_255", {24'd0, press_count}, 255);
    end
    check("wrap_count_0", {24'd0, press_count}, 0);
    check("wrap_presses", n_press - s_press, 256);
    check("wrap_releases", n_release - s_release, 256);

    check("no_overlap", n_overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
